i2c_cmd_arbiter: RTL and testbench
==================================

I2C_CMD_ARBITER -- requirements
Module: i2c_cmd_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 20000, giving the watchdog limit in clk cycles per transaction.
REQ-002 The block SHALL have port clk, input, 1 bit: system clock (40 MHz), all logic on rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port req_valid, input, 2 bits: requester i has a pending transaction.
REQ-005 The block SHALL have port req_addr, input, 14 bits: 7-bit slave address of requester i at [7i+6:7i].
REQ-006 The block SHALL have port req_op, input, 2 bits: requester i operation, 0 = write, 1 = read.
REQ-007 The block SHALL have port req_wdata, input, 16 bits: write byte of requester i at [8i+7:8i].
REQ-008 The block SHALL have port req_ready, output, 2 bits: one-cycle accept pulse to requester i.
REQ-009 The block SHALL have port rsp_valid, output, 2 bits: one-cycle completion pulse to requester i.
REQ-010 The block SHALL have port rsp_rdata, output, 8 bits: read byte, valid with rsp_valid.
REQ-011 The block SHALL have port rsp_err, output, 1 bit: NACK or timeout, valid with rsp_valid.
REQ-012 The block SHALL have port rsp_timeout, output, 1 bit: watchdog expiry, valid with rsp_valid.
REQ-013 The block SHALL have port active, output, 1 bit: FSM not in IDLE.
REQ-014 The block SHALL have master-side outputs m_newd (1), m_addr (7), m_op (1), m_din (8) and m_rst (1, active-high).
REQ-015 The block SHALL have master-side inputs m_dout (8), m_busy (1), m_ack_err (1) and m_done (1).

Function
REQ-016 The FSM SHALL have states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE and RESP; all outputs SHALL be registered.
REQ-017 In IDLE with any req_valid set, the block SHALL pick a winner, latch its addr, op and wdata, record gnt_id, and go to ISSUE.
REQ-018 Arbitration SHALL be round-robin: when both requesters are valid, the one not equal to last_grant wins; when only one is valid, that one wins.
REQ-019 In ISSUE, the block SHALL hold m_newd=1 and req_ready[gnt_id]=1 for exactly one cycle, drive m_addr, m_op and m_din from the latches, clear the watchdog, then go to WAIT_BUSY.
REQ-020 m_addr, m_op and m_din SHALL stay stable from ISSUE until RESP.
REQ-021 In WAIT_BUSY, the block SHALL go to WAIT_DONE on m_busy=1.
REQ-022 In WAIT_DONE, on m_done=1 the block SHALL capture m_dout into rsp_rdata if op=1 (else 0x00), set rsp_err=m_ack_err and rsp_timeout=0, then go to RESP.
REQ-023 The watchdog SHALL count every cycle in WAIT_BUSY and WAIT_DONE; on reaching TIMEOUT-1 without m_done, the block SHALL set rsp_err=1, rsp_timeout=1 and rsp_rdata=0, pulse m_rst for one cycle, and go to RESP.
REQ-024 If m_done and watchdog expiry occur in the same cycle, m_done SHALL win and m_rst SHALL NOT pulse.
REQ-025 In RESP, the block SHALL pulse rsp_valid[gnt_id] for one cycle, set last_grant=gnt_id, and return to IDLE.
REQ-026 rsp_rdata, rsp_err and rsp_timeout SHALL hold their values until the next RESP.
REQ-027 req_valid changes after the accept pulse SHALL be ignored until the FSM returns to IDLE.
REQ-028 Requesters SHALL hold their fields stable while req_valid=1 and before req_ready.
REQ-029 Minimum issue latency SHALL be 2 cycles from req_valid in IDLE to m_newd.
REQ-030 Back-to-back transactions SHALL have at least 1 IDLE cycle between RESP and the next ISSUE.
REQ-031 m_done or m_busy seen while in IDLE SHALL be ignored.

Reset
REQ-032 While rst=0, the block SHALL asynchronously force state to IDLE, last_grant=1 (requester 0 wins first), and every output to 0.
REQ-033 Reset asserted mid-transaction SHALL abort it with no rsp_valid and leave m_newd=0.
REQ-034 After reset release, the block SHALL resume on the first rising clk edge.

Verification
REQ-035 Write: req_valid=01, addr 0x50, op 0, wdata 0xA5, master model ACKs -> m_newd one pulse with m_addr=0x50 and m_din=0xA5; rsp_valid=01 with rsp_err=0.
REQ-036 Read: requester 1, addr 0x28, op 1, slave returns 0x3C -> rsp_valid=10, rsp_rdata=0x3C, rsp_err=0.
REQ-037 Contention: req_valid=11 held after reset -> grant order 0,1,0,1 across four transactions.
REQ-038 NACK: model sets m_ack_err=1 with m_done -> rsp_err=1, rsp_timeout=0, no m_rst pulse.
REQ-039 Hang: model never asserts m_done, TIMEOUT=64 -> m_rst pulse exactly 64 cycles after ISSUE exit; rsp_err=1, rsp_timeout=1.
REQ-040 Reset mid-WAIT_DONE: rst=0 -> all outputs 0 immediately, no rsp_valid; requester 0 wins the next contention.

Source files
------------

// File: rtl/i2c_cmd_arbiter.sv
// i2c_cmd_arbiter: two-requester round-robin front end for a byte-level I2C
// master. It accepts one transaction at a time, hands it to the master,
// supervises it with a watchdog and returns the result to the owner.
// All outputs are registered; clearing rst (active-low) aborts everything.
module i2c_cmd_arbiter #(
   parameter int unsigned TIMEOUT = 20000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  req_valid,
   input  logic [13:0] req_addr,
   input  logic [1:0]  req_op,
   input  logic [15:0] req_wdata,
   output logic [1:0]  req_ready,
   output logic [1:0]  rsp_valid,
   output logic [7:0]  rsp_rdata,
   output logic        rsp_err,
   output logic        rsp_timeout,
   output logic        active,
   output logic        m_newd,
   output logic [6:0]  m_addr,
   output logic        m_op,
   output logic [7:0]  m_din,
   output logic        m_rst,
   input  logic [7:0]  m_dout,
   input  logic        m_busy,
   input  logic        m_ack_err,
   input  logic        m_done
);

   // One spare bit so the counter never wraps before the compare fires.
   localparam int unsigned   WDW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) + 1 : 1;
   localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_BUSY,
      WAIT_DONE,
      RESP
   } state_t;

   state_t         state_q, state_d;
   logic           gnt_q, gnt_d;
   logic           last_grant_q, last_grant_d;
   logic [6:0]     addr_lat_q, addr_lat_d;
   logic           op_lat_q, op_lat_d;
   logic [7:0]     wdata_lat_q, wdata_lat_d;
   logic [WDW-1:0] wdog_q, wdog_d;
   logic           wd_expired;

   logic           win;
   logic [6:0]     pick_addr;
   logic           pick_op;
   logic [7:0]     pick_wdata;

   logic [1:0]     req_ready_d;
   logic [1:0]     rsp_valid_d;
   logic [7:0]     rsp_rdata_d;
   logic           rsp_err_d;
   logic           rsp_timeout_d;
   logic           active_d;
   logic           m_newd_d;
   logic [6:0]     m_addr_d;
   logic           m_op_d;
   logic [7:0]     m_din_d;
   logic           m_rst_d;

   assign wd_expired = (wdog_q >= WD_LAST);

   // State register plus transaction latches and watchdog counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         gnt_q        <= 1'b0;
         last_grant_q <= 1'b1;
         addr_lat_q   <= '0;
         op_lat_q     <= 1'b0;
         wdata_lat_q  <= '0;
         wdog_q       <= '0;
      end else begin
         state_q      <= state_d;
         gnt_q        <= gnt_d;
         last_grant_q <= last_grant_d;
         addr_lat_q   <= addr_lat_d;
         op_lat_q     <= op_lat_d;
         wdata_lat_q  <= wdata_lat_d;
         wdog_q       <= wdog_d;
      end
   end

   // Output registers: every port is driven from a flop.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         req_ready   <= '0;
         rsp_valid   <= '0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
         active      <= 1'b0;
         m_newd      <= 1'b0;
         m_addr      <= '0;
         m_op        <= 1'b0;
         m_din       <= '0;
         m_rst       <= 1'b0;
      end else begin
         req_ready   <= req_ready_d;
         rsp_valid   <= rsp_valid_d;
         rsp_rdata   <= rsp_rdata_d;
         rsp_err     <= rsp_err_d;
         rsp_timeout <= rsp_timeout_d;
         active      <= active_d;
         m_newd      <= m_newd_d;
         m_addr      <= m_addr_d;
         m_op        <= m_op_d;
         m_din       <= m_din_d;
         m_rst       <= m_rst_d;
      end
   end

   // Next-state and next-output logic; outputs lag the state by one cycle.
   always_comb begin
      state_d       = state_q;
      gnt_d         = gnt_q;
      last_grant_d  = last_grant_q;
      addr_lat_d    = addr_lat_q;
      op_lat_d      = op_lat_q;
      wdata_lat_d   = wdata_lat_q;
      wdog_d        = wdog_q;

      req_ready_d   = '0;
      rsp_valid_d   = '0;
      rsp_rdata_d   = rsp_rdata;
      rsp_err_d     = rsp_err;
      rsp_timeout_d = rsp_timeout;
      m_newd_d      = 1'b0;
      m_addr_d      = m_addr;
      m_op_d        = m_op;
      m_din_d       = m_din;
      m_rst_d       = 1'b0;

      // Round-robin: on contention the requester not served last wins.
      win        = (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];
      pick_addr  = win ? req_addr[13:7]  : req_addr[6:0];
      pick_op    = req_op[win];
      pick_wdata = win ? req_wdata[15:8] : req_wdata[7:0];

      case (state_q)
         IDLE: begin
            if (|req_valid) begin
               gnt_d       = win;
               addr_lat_d  = pick_addr;
               op_lat_d    = pick_op;
               wdata_lat_d = pick_wdata;
               state_d     = ISSUE;
            end
         end
         ISSUE: begin
            m_newd_d           = 1'b1;
            req_ready_d[gnt_q] = 1'b1;
            m_addr_d           = addr_lat_q;
            m_op_d             = op_lat_q;
            m_din_d            = wdata_lat_q;
            wdog_d             = '0;
            state_d            = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            wdog_d = wdog_q + WDW'(1);
            if (m_busy) begin
               state_d = WAIT_DONE;
            end else if (wd_expired) begin
               rsp_rdata_d   = '0;
               rsp_err_d     = 1'b1;
               rsp_timeout_d = 1'b1;
               m_rst_d       = 1'b1;
               state_d       = RESP;
            end
         end
         WAIT_DONE: begin
            wdog_d = wdog_q + WDW'(1);
            // m_done is tested first so it wins a tie with the watchdog.
            if (m_done) begin
               rsp_rdata_d   = op_lat_q ? m_dout : 8'h00;
               rsp_err_d     = m_ack_err;
               rsp_timeout_d = 1'b0;
               state_d       = RESP;
            end else if (wd_expired) begin
               rsp_rdata_d   = '0;
               rsp_err_d     = 1'b1;
               rsp_timeout_d = 1'b1;
               m_rst_d       = 1'b1;
               state_d       = RESP;
            end
         end
         RESP: begin
            rsp_valid_d[gnt_q] = 1'b1;
            last_grant_d       = gnt_q;
            state_d            = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      active_d = (state_d != IDLE);
   end

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Scoreboard bench for i2c_cmd_arbiter: requester queues feed the DUT, a
// queue-level arbitration model predicts grant order and responses, a master
// model answers issues, and a monitor checks every rsp_valid pulse.
module tb_i2c_cmd_arbiter;

   localparam int unsigned TO = 64;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req_valid;
   logic [13:0] req_addr;
   logic [1:0]  req_op;
   logic [15:0] req_wdata;
   logic [1:0]  req_ready;
   logic [1:0]  rsp_valid;
   logic [7:0]  rsp_rdata;
   logic        rsp_err;
   logic        rsp_timeout;
   logic        active;
   logic        m_newd;
   logic [6:0]  m_addr;
   logic        m_op;
   logic [7:0]  m_din;
   logic        m_rst;
   logic [7:0]  m_dout;
   logic        m_busy;
   logic        m_ack_err;
   logic        m_done;

   i2c_cmd_arbiter #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_addr(req_addr), .req_op(req_op), .req_wdata(req_wdata),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .active(active),
      .m_newd(m_newd), .m_addr(m_addr), .m_op(m_op), .m_din(m_din), .m_rst(m_rst),
      .m_dout(m_dout), .m_busy(m_busy), .m_ack_err(m_ack_err), .m_done(m_done)
   );

   always #10 clk = ~clk;

   // One transaction plus the slave behaviour it will meet.
   // b/d: negedges after m_newd is first seen at which busy/done are driven.
   typedef struct {
      int unsigned id;
      logic [6:0]  addr;
      logic        op;
      logic [7:0]  wdata;
      logic [7:0]  sdata;
      logic        nack;
      logic        hang;
      logic        abort;
      int unsigned b;
      int unsigned d;
   } item_t;

   typedef struct {
      int unsigned id;
      logic [7:0]  rdata;
      logic        err;
      logic        tmo;
   } rsp_t;

   item_t st0[$], st1[$];   // staging
   item_t rq0[$], rq1[$];   // live requester queues
   item_t mq[$];            // predicted issue order
   rsp_t  sq[$];            // predicted responses

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   int unsigned model_lg = 1;
   int unsigned exp_rst_pulses = 0;
   int unsigned seen_rst_hi = 0;
   bit          master_busy = 1'b0;
   bit          abort_parked = 1'b0;
   bit          stray_en = 1'b0;
   item_t       cur;
   rsp_t        exp_r;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
      end
   endtask

   function automatic item_t mk(input logic [6:0] a, input logic op, input logic [7:0] w,
                                input logic [7:0] s, input logic nack, input logic hang,
                                input logic abort, input int unsigned b, input int unsigned d);
      item_t it;
      it.id = 0; it.addr = a; it.op = op; it.wdata = w; it.sdata = s;
      it.nack = nack; it.hang = hang; it.abort = abort; it.b = b; it.d = d;
      return it;
   endfunction

   function automatic item_t rnd_item();
      item_t it;
      int unsigned kind;
      it = mk(7'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b0,
              $urandom_range(0, 3), 0);
      it.d = it.b + 1 + $urandom_range(0, 10);
      kind = $urandom_range(0, 11);
      if (kind == 0) it.hang = 1'b1;
      else if (kind == 1) it.d = TO - 1;
      else if (kind <= 3) it.nack = 1'b1;
      return it;
   endfunction

   // Reference: queue-level round robin over whatever is staged, then hand
   // the staged items to the requesters.
   task automatic launch();
      item_t c0[$];
      item_t c1[$];
      item_t it;
      rsp_t  r;
      int unsigned w;
      c0 = st0;
      c1 = st1;
      while (c0.size() > 0 || c1.size() > 0) begin
         if (c0.size() > 0 && c1.size() > 0) w = (model_lg == 0) ? 1 : 0;
         else w = (c0.size() > 0) ? 0 : 1;
         if (w == 0) it = c0.pop_front();
         else it = c1.pop_front();
         it.id = w;
         mq.push_back(it);
         if (!it.abort) begin
            r.id    = w;
            r.rdata = it.hang ? 8'h00 : (it.op ? it.sdata : 8'h00);
            r.err   = it.hang | it.nack;
            r.tmo   = it.hang;
            sq.push_back(r);
            model_lg = w;
            if (it.hang) exp_rst_pulses++;
         end
      end
      rq0 = st0;
      rq1 = st1;
      st0.delete();
      st1.delete();
   endtask

   task automatic wait_idle(input string tag);
      bit done;
      done = 1'b0;
      for (int c = 0; c < 8000 && !done; c++) begin
         @(negedge clk);
         if (rq0.size() == 0 && rq1.size() == 0 && mq.size() == 0 && sq.size() == 0 && !master_busy)
            done = 1'b1;
      end
      if (!done) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain_%s: pending rq0=%0d rq1=%0d mq=%0d sq=%0d, required all 0",
                  tag, rq0.size(), rq1.size(), mq.size(), sq.size());
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic chk_zero();
      chk("rst_req_ready",   32'(req_ready),   32'(0));
      chk("rst_rsp_valid",   32'(rsp_valid),   32'(0));
      chk("rst_rsp_rdata",   32'(rsp_rdata),   32'(0));
      chk("rst_rsp_err",     32'(rsp_err),     32'(0));
      chk("rst_rsp_timeout", 32'(rsp_timeout), 32'(0));
      chk("rst_active",      32'(active),      32'(0));
      chk("rst_m_newd",      32'(m_newd),      32'(0));
      chk("rst_m_addr",      32'(m_addr),      32'(0));
      chk("rst_m_op",        32'(m_op),        32'(0));
      chk("rst_m_din",       32'(m_din),       32'(0));
      chk("rst_m_rst",       32'(m_rst),       32'(0));
   endtask

   task automatic pulse_reset();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      model_lg = 1;
   endtask

   // Slave-side timeline for one accepted transaction.
   task automatic run_txn(input item_t it);
      for (int unsigned n = 0; n <= 200; n++) begin
         if (n > 0) @(negedge clk);
         m_busy    = (n == it.b);
         m_done    = (!it.hang && !it.abort && n == it.d);
         m_dout    = (n == it.d) ? it.sdata : 8'($urandom);
         m_ack_err = (n == it.d) ? it.nack : 1'($urandom);
         if (n == 1) chk("m_newd_single_pulse", 32'(m_newd), 32'(0));
         if (it.abort && n == it.b + 1) begin
            m_busy = 1'b0;
            abort_parked = 1'b1;
            return;
         end
         if (!it.hang && !it.abort && n == it.d) begin
            chk("m_addr_stable", 32'(m_addr), 32'(it.addr));
            chk("m_din_stable",  32'(m_din),  32'(it.wdata));
            return;
         end
         if (it.hang && m_rst === 1'b1) begin
            chk("wdog_latency", 32'(n), 32'(TO));
            return;
         end
      end
      n_cmp++;
      n_bad++;
      $display("FAIL txn_bound: transaction to addr 0x%0h not finished in 200 cycles, required completion", it.addr);
   endtask

   // Requesters: present the queue head while non-empty, pop on accept.
   initial begin
      req_valid = '0; req_addr = '0; req_op = '0; req_wdata = '0;
      forever begin
         @(negedge clk);
         if (req_ready[0] && rq0.size() > 0) void'(rq0.pop_front());
         if (req_ready[1] && rq1.size() > 0) void'(rq1.pop_front());
         if (rq0.size() > 0) begin
            req_valid[0] = 1'b1; req_addr[6:0] = rq0[0].addr;
            req_op[0] = rq0[0].op; req_wdata[7:0] = rq0[0].wdata;
         end else begin
            req_valid[0] = 1'b0; req_addr[6:0] = 7'($urandom);
            req_op[0] = 1'($urandom); req_wdata[7:0] = 8'($urandom);
         end
         if (rq1.size() > 0) begin
            req_valid[1] = 1'b1; req_addr[13:7] = rq1[0].addr;
            req_op[1] = rq1[0].op; req_wdata[15:8] = rq1[0].wdata;
         end else begin
            req_valid[1] = 1'b0; req_addr[13:7] = 7'($urandom);
            req_op[1] = 1'($urandom); req_wdata[15:8] = 8'($urandom);
         end
      end
   end

   // Master model: checks each issue against the predicted order.
   initial begin
      m_busy = 1'b0; m_done = 1'b0; m_ack_err = 1'b0; m_dout = '0;
      forever begin
         @(negedge clk);
         m_busy = 1'b0; m_done = 1'b0;
         m_ack_err = 1'($urandom); m_dout = 8'($urandom);
         if (m_newd === 1'b1) begin
            if (mq.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_issue: m_newd=1 addr=0x%0h, required no issue", m_addr);
            end else begin
               cur = mq.pop_front();
               master_busy  = 1'b1;
               abort_parked = 1'b0;
               chk("issue_m_addr",    32'(m_addr),    32'(cur.addr));
               chk("issue_m_op",      32'(m_op),      32'(cur.op));
               chk("issue_m_din",     32'(m_din),     32'(cur.wdata));
               chk("issue_req_ready", 32'(req_ready), 32'(1) << cur.id);
               run_txn(cur);
               master_busy = 1'b0;
            end
         end else if (stray_en && $urandom_range(0, 2) == 0) begin
            m_busy = 1'b1; m_done = 1'b1; m_ack_err = 1'b1;
         end
      end
   end

   // Response monitor.
   initial begin
      forever begin
         @(negedge clk);
         if (m_rst === 1'b1) seen_rst_hi++;
         if (rsp_valid !== 2'b00) begin
            if (sq.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_rsp: rsp_valid=%b, required 00", rsp_valid);
            end else begin
               exp_r = sq.pop_front();
               chk("rsp_valid",   32'(rsp_valid),   32'(1) << exp_r.id);
               chk("rsp_rdata",   32'(rsp_rdata),   32'(exp_r.rdata));
               chk("rsp_err",     32'(rsp_err),     32'(exp_r.err));
               chk("rsp_timeout", 32'(rsp_timeout), 32'(exp_r.tmo));
            end
         end
      end
   end

   initial begin
      bit parked;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk_zero();
      rst = 1'b1;
      @(negedge clk);

      // Directed write, read, NACK, hang and done/expiry tie.
      st0.push_back(mk(7'h50, 1'b0, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b0, 2, 6));
      launch(); wait_idle("write");
      st1.push_back(mk(7'h28, 1'b1, 8'h11, 8'h3C, 1'b0, 1'b0, 1'b0, 1, 5));
      launch(); wait_idle("read");
      st0.push_back(mk(7'h42, 1'b0, 8'h99, 8'h00, 1'b1, 1'b0, 1'b0, 0, 3));
      launch(); wait_idle("nack");
      st1.push_back(mk(7'h33, 1'b1, 8'h00, 8'h77, 1'b0, 1'b1, 1'b0, 1, 0));
      launch(); wait_idle("hang");
      st0.push_back(mk(7'h61, 1'b1, 8'h00, 8'hC3, 1'b0, 1'b0, 1'b0, 2, TO - 1));
      launch(); wait_idle("tie");

      // Stray master strobes while idle must be ignored.
      stray_en = 1'b1;
      repeat (20) @(negedge clk);
      stray_en = 1'b0;
      repeat (2) @(negedge clk);
      chk("stray_idle_active", 32'(active), 32'(0));

      // Contention straight after reset: 0,1,0,1.
      pulse_reset();
      for (int k = 0; k < 2; k++) begin
         st0.push_back(mk(7'h10 + 7'(k), 1'b1, 8'h00, 8'hA0 + 8'(k), 1'b0, 1'b0, 1'b0, 1, 4));
         st1.push_back(mk(7'h20 + 7'(k), 1'b0, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b0, 0, 2));
      end
      launch(); wait_idle("contention");

      // Randomized mix.
      for (int k = 0; k < 30; k++) begin
         if ($urandom_range(0, 1) == 0) st0.push_back(rnd_item());
         else st1.push_back(rnd_item());
      end
      launch(); wait_idle("random");

      // Leave last_grant at 0, then reset in the middle of WAIT_DONE.
      st0.push_back(mk(7'h0F, 1'b1, 8'h00, 8'h81, 1'b0, 1'b0, 1'b0, 0, 2));
      launch(); wait_idle("pre_abort");
      st0.push_back(mk(7'h55, 1'b1, 8'hEE, 8'h00, 1'b0, 1'b0, 1'b1, 2, 0));
      launch();
      parked = 1'b0;
      for (int c = 0; c < 200 && !parked; c++) begin
         @(negedge clk);
         parked = abort_parked;
      end
      chk("abort_reached_wait_done", 32'(parked), 32'(1));
      repeat (2) @(negedge clk);
      chk("abort_active_before_rst", 32'(active), 32'(1));
      rst = 1'b0;
      #1;
      chk_zero();
      repeat (3) @(negedge clk);
      rst = 1'b1;
      model_lg = 1;
      st0.push_back(mk(7'h12, 1'b0, 8'h3E, 8'h00, 1'b0, 1'b0, 1'b0, 1, 3));
      st1.push_back(mk(7'h24, 1'b1, 8'h00, 8'h6B, 1'b0, 1'b0, 1'b0, 1, 3));
      launch(); wait_idle("post_abort");

      chk("m_rst_pulse_cycles", 32'(seen_rst_hi), 32'(exp_rst_pulses));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
